// File: rtl/arm_pkg.sv
// Shared types and constants for the memory-access stage: FSM state
// encoding, default SRAM base address and SRAM data width.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int ARM_BASE_ADDR = 1024;
  localparam int SRAM_DW       = 16;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter that times one SRAM half-access; o_tc is high while the
// count sits at zero, i.e. on the last cycle of the half.
module sram_wait_counter
  import arm_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/mem_stage_sram.sv
// Memory-access stage: splits each 32-bit load/store into two 16-bit SRAM
// accesses with a programmable wait. Define MEM_POSTED_WRITE_EN to post stores.
//
// state | meaning
// IDLE  | waiting for a request; request seen here starts an access
// LO    | low halfword access, held WAIT_CYCLES cycles
// HI    | high halfword access, held WAIT_CYCLES cycles
// DONE  | load data valid, stage released for one cycle
module mem_stage_sram
  import arm_pkg::*;
#(
  parameter int BASE_ADDR   = ARM_BASE_ADDR,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [CNT_W-1:0] LP_CNT_LD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t r_state, w_next_state;

  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_sram_dq_o;
  logic               r_sram_dq_oe;
  logic               r_sram_we_n;
  logic [31:0]        r_mem_data;
  logic [SRAM_DW-1:0] r_lo_half;

  logic               w_req;
  logic               w_store;
  logic [SRAM_AW-2:0] w_word;
  logic [SRAM_AW-2:0] w_cur_word;
  logic [SRAM_DW-1:0] w_cur_data_hi;
  logic               w_cur_store;
  logic               w_accept_ready;
  logic               w_skip_done;
  logic               w_cnt_load;
  logic               w_cnt_dec;
  logic               w_tc;
  logic               w_ready;

  assign w_req   = mem_r_en | mem_w_en;
  // A simultaneous read and write request is treated as a read only.
  assign w_store = mem_w_en & ~mem_r_en;
  assign w_word  = (SRAM_AW-1)'((alu_res - 32'(BASE_ADDR)) >> 2);

`ifdef MEM_POSTED_WRITE_EN
  logic [SRAM_AW-2:0] r_buf_word;
  logic [SRAM_DW-1:0] r_buf_data_hi;
  logic               r_buf_store;

  // Requests are captured at acceptance so a posted store can drain after
  // the pipeline has already moved on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_word    <= '0;
      r_buf_data_hi <= '0;
      r_buf_store   <= 1'b0;
    end else if ((r_state == IDLE) && w_req) begin
      r_buf_word    <= w_word;
      r_buf_data_hi <= val_rm[31:16];
      r_buf_store   <= w_store;
    end
  end

  assign w_cur_word     = r_buf_word;
  assign w_cur_data_hi  = r_buf_data_hi;
  assign w_cur_store    = r_buf_store;
  assign w_accept_ready = w_store;
  assign w_skip_done    = r_buf_store;
`else
  assign w_cur_word     = w_word;
  assign w_cur_data_hi  = val_rm[31:16];
  assign w_cur_store    = w_store;
  assign w_accept_ready = 1'b0;
  assign w_skip_done    = 1'b0;
`endif

  sram_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LP_CNT_LD),
    .i_dec      (w_cnt_dec),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next_state = LO;
          w_cnt_load   = 1'b1;
          w_ready      = w_accept_ready;
        end else begin
          w_ready = 1'b1;
        end
      end
      LO: begin
        if (w_tc) begin
          w_next_state = HI;
          w_cnt_load   = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      HI: begin
        if (w_tc) begin
          w_next_state = w_skip_done ? IDLE : DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      DONE: begin
        w_ready      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // SRAM pins only move on the edges entering or leaving LO and HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_addr  <= '0;
      r_sram_dq_o  <= '0;
      r_sram_dq_oe <= 1'b0;
      r_sram_we_n  <= 1'b1;
      r_mem_data   <= '0;
      r_lo_half    <= '0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_sram_addr  <= {w_word, 1'b0};
        r_sram_dq_o  <= val_rm[15:0];
        r_sram_dq_oe <= w_store;
        r_sram_we_n  <= ~w_store;
      end
      if ((r_state == LO) && w_tc) begin
        r_sram_addr <= {w_cur_word, 1'b1};
        r_sram_dq_o <= w_cur_data_hi;
        r_lo_half   <= sram_dq_i;
      end
      if ((r_state == HI) && w_tc) begin
        r_sram_dq_oe <= 1'b0;
        r_sram_we_n  <= 1'b1;
        if (!w_cur_store) begin
          r_mem_data <= {sram_dq_i, r_lo_half};
        end
      end
    end
  end

  assign ready      = w_ready;
  assign mem_data   = r_mem_data;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_sram_dq_oe;
  assign sram_we_n  = r_sram_we_n;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: expectations are queued at issue and
// checked by per-DUT monitors when the stage releases (ready with a request).
module tb_mem_stage_sram;

  typedef struct {
    logic [31:0] data;
    int          stall;
    int          lo;
    int          hi;
    logic [17:0] a0;
    int          wr;
    bit          wchk;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en0, w_en0, r_en1, w_en1;
  logic [31:0] alu0, val0, alu1, val1;
  logic [31:0] md0, md1;
  logic        ready0, ready1;
  logic [17:0] addr0, addr1;
  logic [15:0] dqo0, dqi0, dqo1, dqi1;
  logic        oe0, we0, oe1, we1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic        pre_en0, pre_en1;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;

  exp_t q0[$];
  exp_t q1[$];
  int   m_stall [2];
  int   m_lo    [2];
  int   m_hi    [2];
  bit   m_wr    [2];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] last0;

  mem_stage_sram #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0),
    .alu_res(alu0), .val_rm(val0), .mem_data(md0), .ready(ready0),
    .sram_addr(addr0), .sram_dq_o(dqo0), .sram_dq_i(dqi0),
    .sram_dq_oe(oe0), .sram_we_n(we0)
  );

  mem_stage_sram #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1),
    .alu_res(alu1), .val_rm(val1), .mem_data(md1), .ready(ready1),
    .sram_addr(addr1), .sram_dq_o(dqo1), .sram_dq_i(dqi1),
    .sram_dq_oe(oe1), .sram_we_n(we1)
  );

  always @(posedge clk) begin
    if (pre_en0) mem0[pre_a] <= pre_d;
    else if (!we0 && oe0) mem0[addr0[5:0]] <= dqo0;
    if (pre_en1) mem1[pre_a] <= pre_d;
    else if (!we1 && oe1) mem1[addr1[5:0]] <= dqo1;
  end

  assign dqi0 = mem0[addr0[5:0]];
  assign dqi1 = mem1[addr1[5:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] data, input int stall, input int lo,
                              input int hi, input logic [17:0] a0, input int wr,
                              input bit wchk, input logic [31:0] wdata);
    exp_t e;
    e.data = data; e.stall = stall; e.lo = lo; e.hi = hi;
    e.a0 = a0; e.wr = wr; e.wchk = wchk; e.wdata = wdata;
    return e;
  endfunction

  task automatic mon(input int k, input logic rdy, input logic req, input logic [17:0] ad,
                     input logic wen, input logic [31:0] md);
    exp_t e;
    bit   have;
    logic [15:0] lo_w, hi_w;
    if (!rst) begin
      m_stall[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_wr[k] = 0;
      return;
    end
    if (!req) return;
    have = 0;
    if (k == 0 && q0.size() > 0) begin have = 1; e = q0[0]; end
    if (k == 1 && q1.size() > 0) begin have = 1; e = q1[0]; end
    if (!rdy) begin
      if (have && m_stall[k] > 0) begin
        if (ad == e.a0) m_lo[k]++;
        else if (ad == (e.a0 | 18'd1)) m_hi[k]++;
      end
      if (!wen) m_wr[k] = 1;
      m_stall[k]++;
    end else begin
      check($sformatf("txn_expected_dut%0d", k), 32'(have), 32'd1);
      if (have) begin
        if (k == 0) begin
          e = q0.pop_front();
          lo_w = mem0[e.a0[5:0]]; hi_w = mem0[e.a0[5:0] | 6'd1];
        end else begin
          e = q1.pop_front();
          lo_w = mem1[e.a0[5:0]]; hi_w = mem1[e.a0[5:0] | 6'd1];
        end
        check($sformatf("mem_data_dut%0d", k), md, e.data);
        check($sformatf("ready_low_cycles_dut%0d", k), 32'(m_stall[k]), 32'(e.stall));
        if (e.lo >= 0) check($sformatf("lo_addr_hold_dut%0d", k), 32'(m_lo[k]), 32'(e.lo));
        if (e.hi >= 0) check($sformatf("hi_addr_hold_dut%0d", k), 32'(m_hi[k]), 32'(e.hi));
        if (e.wr >= 0) check($sformatf("sram_write_seen_dut%0d", k), 32'(m_wr[k]), 32'(e.wr));
        if (e.wchk) begin
          check($sformatf("sram_lo_half_dut%0d", k), 32'(lo_w), 32'(e.wdata[15:0]));
          check($sformatf("sram_hi_half_dut%0d", k), 32'(hi_w), 32'(e.wdata[31:16]));
        end
      end
      m_stall[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_wr[k] = 0;
    end
  endtask

  always @(negedge clk) mon(0, ready0, r_en0 | w_en0, addr0, we0, md0);
  always @(negedge clk) mon(1, ready1, r_en1 | w_en1, addr1, we1, md1);

  task automatic preload(input int k, input logic [5:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d;
    if (k == 0) pre_en0 = 1'b1; else pre_en1 = 1'b1;
    @(posedge clk); #1;
    pre_en0 = 1'b0; pre_en1 = 1'b0;
  endtask

  task automatic issue(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e);
    bit ok = 0;
    if (k == 0) begin
      q0.push_back(e); r_en0 = r; w_en0 = w; alu0 = a; val0 = d;
    end else begin
      q1.push_back(e); r_en1 = r; w_en1 = w; alu1 = a; val1 = d;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((k == 0) ? ready0 : ready1) begin ok = 1; break; end
    end
    if (!ok) check($sformatf("ready_timeout_dut%0d", k), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    r_en0 = 0; w_en0 = 0; r_en1 = 0; w_en1 = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit hit;
    r_en0 = 0; w_en0 = 0; alu0 = 0; val0 = 0;
    r_en1 = 0; w_en1 = 0; alu1 = 0; val1 = 0;
    pre_en0 = 0; pre_en1 = 0; pre_a = 0; pre_d = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_ready", 32'(ready0), 32'd1);
    check("reset_we_n", 32'(we0), 32'd1);
    check("reset_dq_oe", 32'(oe0), 32'd0);
    check("reset_mem_data", md0, 32'd0);
    check("reset_sram_addr", 32'(addr0), 32'd0);
    check("reset_dq_o", 32'(dqo0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    preload(0, 6'd2, 16'h1234);
    preload(0, 6'd3, 16'hABCD);
    preload(0, 6'd4, 16'h1111);
    preload(0, 6'd5, 16'h2222);
    preload(1, 6'd6, 16'h5A5A);
    preload(1, 6'd7, 16'hC3C3);
    last0 = 32'd0;

`ifdef MEM_POSTED_WRITE_EN
    issue(0, 0, 1, 32'd1024, 32'hDEADBEEF, mk(last0, 0, -1, -1, 18'd0, -1, 0, 32'd0));
`else
    issue(0, 0, 1, 32'd1024, 32'hDEADBEEF, mk(last0, 3, 1, 1, 18'd0, 1, 1, 32'hDEADBEEF));
`endif
    idle(4);

    issue(0, 1, 0, 32'd1028, 32'd0, mk(32'hABCD1234, 3, 1, 1, 18'd2, 0, 0, 32'd0));
    last0 = 32'hABCD1234;
    idle(2);

    issue(1, 1, 0, 32'd1036, 32'd0, mk(32'hC3C35A5A, 7, 3, 3, 18'd6, 0, 0, 32'd0));
    idle(2);

    issue(0, 1, 1, 32'd1032, 32'hFFFFFFFF, mk(32'h22221111, 3, 1, 1, 18'd4, 0, 0, 32'd0));
    issue(0, 1, 0, 32'd1028, 32'd0, mk(32'hABCD1234, 3, 1, 1, 18'd2, 0, 0, 32'd0));
    idle(2);

`ifdef MEM_POSTED_WRITE_EN
    issue(0, 0, 1, 32'd1040, 32'h0BADF00D, mk(last0, 0, -1, -1, 18'd8, -1, 0, 32'd0));
    issue(0, 1, 0, 32'd1040, 32'd0, mk(32'h0BADF00D, 5, -1, -1, 18'd8, -1, 0, 32'd0));
`else
    issue(0, 0, 1, 32'd1040, 32'h0BADF00D, mk(last0, 3, 1, 1, 18'd8, 1, 1, 32'h0BADF00D));
    issue(0, 1, 0, 32'd1040, 32'd0, mk(32'h0BADF00D, 3, 1, 1, 18'd8, 0, 0, 32'd0));
`endif
    last0 = 32'h0BADF00D;
    idle(2);

    // Store to 1044 (halfwords 10/11), reset while the high half is on the pins.
    w_en0 = 1'b1; alu0 = 32'd1044; val0 = 32'h12345678;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (addr0 == 18'd11 && we0 == 1'b0) begin hit = 1; break; end
    end
    check("store_reached_hi", 32'(hit), 32'd1);
    rst = 1'b0; w_en0 = 1'b0;
    #1;
    check("midreset_ready", 32'(ready0), 32'd1);
    check("midreset_we_n", 32'(we0), 32'd1);
    check("midreset_dq_oe", 32'(oe0), 32'd0);
    check("midreset_sram_addr", 32'(addr0), 32'd0);
    check("midreset_dq_o", 32'(dqo0), 32'd0);
    check("midreset_mem_data", md0, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    last0 = 32'd0;
    idle(1);

    issue(0, 1, 0, 32'd1028, 32'd0, mk(32'hABCD1234, 3, 1, 1, 18'd2, 0, 0, 32'd0));
    idle(3);

    check("scoreboard_drained_dut0", 32'(q0.size()), 32'd0);
    check("scoreboard_drained_dut1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
